// File: rtl/mavg_pkg.sv
// Shared constants, sample type and width helper for the moving-average filter.
package mavg_pkg;

    localparam int DATA_W_DEFAULT     = 24;
    localparam int LOG2_DEPTH_DEFAULT = 3;
    localparam int N_CH_DEFAULT       = 2;

    // Native codec sample: 24-bit two's-complement.
    typedef logic signed [23:0] sample_t;

    // Index width for a channel tag; a single channel still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mavg_channel_hist.sv
// Single-channel slice: DEPTH-entry history, write pointer and running sum.
// avg_next is the average that results if the current din is written this
// cycle, so the top can register it without a second adder.
module mavg_channel_hist
    import mavg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     we,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] avg_next
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;

    logic signed [DATA_W-1:0]  hist_q [DEPTH];
    logic signed [DATA_W-1:0]  hist_d [DEPTH];
    logic [LOG2_DEPTH-1:0]     wp_q, wp_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic signed [SUM_W-1:0]   sum_upd;
    logic signed [DATA_W-1:0]  oldest;

    // Running-sum update (add newest, drop oldest) and next-state selection.
    always_comb begin
        oldest   = hist_q[wp_q];
        sum_upd  = sum_q
                 + {{LOG2_DEPTH{din[DATA_W-1]}}, din}
                 - {{LOG2_DEPTH{oldest[DATA_W-1]}}, oldest};
        // Arithmetic shift by LOG2_DEPTH == taking the top DATA_W bits.
        avg_next = sum_upd[SUM_W-1:LOG2_DEPTH];

        hist_d = hist_q;
        wp_d   = wp_q;
        sum_d  = sum_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_d[i] = '0;
            end
            wp_d  = '0;
            sum_d = '0;
        end else if (we) begin
            hist_d[wp_q] = din;
            wp_d         = wp_q + LOG2_DEPTH'(1);
            sum_d        = sum_upd;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            wp_q  <= '0;
            sum_q <= '0;
        end else begin
            hist_q <= hist_d;
            wp_q   <= wp_d;
            sum_q  <= sum_d;
        end
    end

endmodule

// File: rtl/sample_mavg_filter.sv
// Multi-channel boxcar filter for signed audio samples with bypass and clear.
// Handshake: a sample is accepted when in_valid=1, in_ch<N_CH and clear=0;
// exactly one cycle later out_valid pulses high for one cycle with out_ch and
// out_data. There is no ready: downstream must take every out_valid pulse.
// When nothing is accepted, out_ch/out_data keep their last values.
module sample_mavg_filter
    import mavg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEFAULT,
    parameter int N_CH       = N_CH_DEFAULT,
    parameter int CH_W       = clog2_min1(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     bypass,
    input  logic                     clear,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_data
);

    logic                     accept;
    logic [N_CH-1:0]          we;
    logic signed [DATA_W-1:0] avg_nx [N_CH];
    logic signed [DATA_W-1:0] avg_sel;

    logic                     out_valid_q, out_valid_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;

    // Out-of-range channel tags and clear both suppress acceptance.
    always_comb begin
        accept = in_valid && (int'(in_ch) < N_CH) && !clear;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign we[g] = accept && (int'(in_ch) == g);

        mavg_channel_hist #(
            .DATA_W     (DATA_W),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_hist (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .we       (we[g]),
            .din      (in_data),
            .avg_next (avg_nx[g])
        );
    end

    // Select the addressed channel's new average and form the next outputs.
    always_comb begin
        avg_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (int'(in_ch) == c) begin
                avg_sel = avg_nx[c];
            end
        end

        out_valid_d = accept;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_ch_d   = in_ch;
            out_data_d = bypass ? in_data : avg_sel;
        end
    end

    // Output registers; reset zeroes them, clear only drops out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sample_mavg_filter.sv
// Directed bench for sample_mavg_filter: a table of single-cycle vectors with
// hand-derived expectations, plus a hand-written mid-stream reset sequence.
// Three channels are built so that tag 3 is representable and out of range.
module tb_sample_mavg_filter;

    localparam int DATA_W     = 24;
    localparam int LOG2_DEPTH = 3;
    localparam int N_CH       = 3;
    localparam int CH_W       = 2;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] in_data;
    logic                     bypass;
    logic                     clear;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;

    typedef struct {
        logic              valid;
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
        logic              byp;
        logic              clr;
        logic              exp_valid;
        logic [CH_W-1:0]   exp_ch;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t              vecs[$];
    logic [DATA_W-1:0] exp_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;

    sample_mavg_filter #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH),
        .N_CH       (N_CH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .bypass    (bypass),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input int ch, input int d, input logic b,
                       input logic c, input logic ev, input int ech, input int ed);
        vec_t x;
        x.valid     = v;
        x.ch        = CH_W'(ch);
        x.data      = DATA_W'(d);
        x.byp       = b;
        x.clr       = c;
        x.exp_valid = ev;
        x.exp_ch    = CH_W'(ech);
        x.exp_data  = DATA_W'(ed);
        vecs.push_back(x);
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_ch    = '0;
        in_data  = '0;
        bypass   = 1'b0;
        clear    = 1'b0;
    endtask

    // Drive one vector, let one edge pass, then compare outputs.
    task automatic apply(input vec_t x, input int idx);
        logic [DATA_W-1:0] e;
        in_valid = x.valid;
        in_ch    = x.ch;
        in_data  = x.data;
        bypass   = x.byp;
        clear    = x.clr;
        exp_q.push_back(x.exp_data);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d_valid", idx), DATA_W'(out_valid), DATA_W'(x.exp_valid));
        check($sformatf("v%0d_ch", idx), DATA_W'(out_ch), DATA_W'(x.exp_ch));
        check($sformatf("v%0d_data", idx), out_data, e);
    endtask

    initial begin
        int ch1_ramp[7];
        int ch1_il[8];
        ch1_ramp = '{-2, -3, -4, -5, -6, -7, -8};
        ch1_il   = '{-7, -5, -4, -2, -1, 1, 2, 4};

        // Reset
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", DATA_W'(out_valid), '0);
        check("rst_ch", DATA_W'(out_ch), '0);
        check("rst_data", out_data, '0);
        reset = 1'b0;

        // Ramp up on ch0 with 8s, then back down with 0s (pointer wrap).
        for (int k = 1; k <= 8; k++) add(1, 0, 8, 0, 0, 1, 0, k);
        for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 0, 1, 0, 8 - k);

        // Negative values and floor rounding on ch1.
        add(1, 1, -1, 0, 0, 1, 1, -1);
        for (int k = 0; k < 7; k++) add(1, 1, -8, 0, 0, 1, 1, ch1_ramp[k]);
        add(0, 0, 123, 0, 0, 0, 1, -8);

        // Full-scale positive then negative on ch0.
        for (int k = 1; k <= 8; k++)
            add(1, 0, 'h7FFFFF, 0, 0, 1, 0, int'((longint'(k) * 8388607) >>> 3));
        for (int k = 1; k <= 8; k++)
            add(1, 0, 'h800000, 0, 0, 1, 0,
                int'((longint'(8 - k) * 8388607 - longint'(k) * 8388608) >>> 3));

        // Interleaved ch0=10 / ch1=4.
        for (int k = 1; k <= 8; k++) begin
            add(1, 0, 10, 0, 0, 1, 0, -1048576 * (8 - k) + (10 * k) / 8);
            add(1, 1, 4, 0, 0, 1, 1, ch1_il[k-1]);
        end

        // Bypass passes 100 through but still enters the history.
        add(1, 0, 100, 1, 0, 1, 0, 100);
        add(1, 0, 10, 0, 0, 1, 0, 21);

        // Clear drops the coincident sample and flushes every channel.
        add(1, 0, 50, 0, 1, 0, 0, 21);
        add(1, 0, 16, 0, 0, 1, 0, 2);
        add(1, 1, 8, 0, 0, 1, 1, 1);

        // Out-of-range tag is ignored and changes nothing.
        add(1, 3, 999, 0, 0, 0, 1, 1);
        add(1, 0, 16, 0, 0, 1, 0, 4);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Mid-stream reset beats a coincident sample and zeroes the outputs.
        in_valid = 1'b1; in_ch = 2'd0; in_data = 24'sd40; bypass = 1'b0; clear = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_data", out_data, DATA_W'(9));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", DATA_W'(out_valid), '0);
        check("mid_rst_ch", DATA_W'(out_ch), '0);
        check("mid_rst_data", out_data, '0);
        reset = 1'b0;
        in_data = 24'sd8;
        @(posedge clk);
        #1;
        check("post_rst_valid", DATA_W'(out_valid), DATA_W'(1));
        check("post_rst_data", out_data, DATA_W'(1));
        drive_idle();
        @(posedge clk);
        #1;
        check("post_rst_idle", DATA_W'(out_valid), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_mavg_filter.md
Name: sample_mavg_filter

Overview:
- Parametrised, multi-channel moving-average (boxcar) filter for 24-bit signed audio samples.
- Next generation of the single-channel data_in/data_out processing sub-system.
- Sits between the codec read path (left/right sample stream) and the codec write path.
- Adds a valid handshake, a channel tag, configurable depth, running-sum arithmetic, bypass and clear.

Parameters:
DATA_W, 24, sample width in bits, two's-complement signed
LOG2_DEPTH, 3, log2 of window length; DEPTH = 2**LOG2_DEPTH taps per channel (range 1..6)
N_CH, 2, number of independent channels (0 = left, 1 = right); range 1..8
CH_W, 1, channel index width = max(1, clog2(N_CH)); derived, not overridden

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_data/in_ch qualify a new sample this cycle
in_ch  in  CH_W  channel of incoming sample
in_data  in  DATA_W  signed input sample
bypass  in  1  1: out_data = in_data (history still updated); sampled with in_valid
clear  in  1  synchronous flush of all channel histories and sums
out_valid  out  1  one-cycle pulse, out_data valid
out_ch  out  CH_W  channel of out_data
out_data  out  DATA_W  signed filtered (or bypassed) sample

Behaviour:
- One clock, synchronous active-high reset.
- Reset: out_valid=0, out_ch=0, out_data=0; every history entry, running sum and write pointer = 0.
- Per channel state:
  - History RAM/regfile of DEPTH x DATA_W.
  - Write pointer wp[LOG2_DEPTH-1:0].
  - Running sum of width DATA_W+LOG2_DEPTH, signed; cannot overflow.
- Accepted sample: in_valid=1, in_ch<N_CH, clear=0. On the rising edge:
  - sum[c] <= sum[c] + in_data - hist[c][wp[c]] (oldest entry, sign-extended).
  - hist[c][wp[c]] <= in_data.
  - wp[c] <= wp[c]+1; wraps DEPTH-1 -> 0 naturally.
  - out_valid <= 1, out_ch <= in_ch.
  - out_data <= bypass ? in_data : (new sum >>> LOG2_DEPTH), arithmetic shift (floor toward -inf), truncated to DATA_W (always fits).
- Latency: exactly 1 cycle from accepted sample to out_valid. Throughput one sample per cycle, any channel order, back-to-back allowed.
- No accepted sample: out_valid <= 0; out_ch/out_data hold last values.
- in_ch >= N_CH: sample ignored, no state change, out_valid <= 0.
- Warm-up: history starts at zero, so the first DEPTH outputs of a channel ramp; no special case.
- clear=1: all histories, sums and pointers <= 0 next edge; out_valid <= 0. Clear wins over a simultaneous in_valid (sample dropped). out_data/out_ch hold.
- Reset mid-stream: same as clear, plus outputs zeroed; highest priority.
- Channels fully isolated: a sample on channel a never alters channel b's sum/history/pointer.
- No back-pressure: downstream must accept every out_valid pulse.
- No FSM beyond per-channel pointer state; combinational path limited to one adder/subtractor plus shift.

Decomposition:
- Shared package mavg_pkg:
  - Constants DATA_W_DEFAULT=24, LOG2_DEPTH_DEFAULT=3, N_CH_DEFAULT=2.
  - Function clog2_min1.
  - Typedef sample_t (signed [23:0]).
- One sub-module: mavg_channel_hist, a single-channel history + pointer + running-sum slice with write enable and clear.
  - Instantiated N_CH times via generate.
  - Top muxes by in_ch and registers the output.

Test Plan:
- Reset, then ch0 in_valid with in_data=8 for 8 consecutive cycles -> out_data 1,2,3,4,5,6,7,8, out_valid each cycle delayed 1, out_ch=0.
- Continue ch0 with eight samples of 0 -> 7,6,5,4,3,2,1,0, verifying wrap of wp and subtraction of the oldest sample.
- Negative and floor: ch1 one sample -1 -> out_data=-1 (0xFFFFFF); then -8 repeated x7 -> final sum -57 -> out_data=-8; ch0 outputs unaffected.
- Full scale: ch0 eight samples 0x7FFFFF -> final out_data 0x7FFFFF; eight samples 0x800000 -> final 0x800000; no overflow.
- Interleaved ch0=10/ch1=4 alternating, 16 samples -> ch0 settles to 10, ch1 to 4. bypass=1 on one sample of 100 -> out_data=100, and the next non-bypass output includes 100 in its average.
- clear asserted with in_valid (data=50) -> out_valid=0 next cycle. Next sample 16 on ch0 -> out_data=2. in_ch=2 with N_CH=2 -> no out_valid. Reset mid-stream -> outputs 0.
